// File: rtl/scheduler_pkg.sv
// Shared types and helpers for the block scheduler: FSM state encoding and
// a ceiling-divide used to turn a thread count into a block count.
package scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        RESET_CORES = 2'd1,
        DISPATCH    = 2'd2,
        DONE        = 2'd3
    } sched_state_t;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: grants the first requester found
// scanning upward from ptr with wrap-around. The grant is one-hot or zero.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          valid
);

    int unsigned scan_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = (int'(ptr) + k) % N;
            if (!valid && req[PW'(scan_idx)]) begin
                grant[PW'(scan_idx)] = 1'b1;
                grant_idx            = PW'(scan_idx);
                valid                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_scheduler.sv
// Splits a kernel into fixed-size thread blocks and dispatches them to cores
// round-robin. Define SCHED_CYCLE_COUNTER_EN to add the kernel_cycles output.
module block_scheduler
    import scheduler_pkg::*;
#(
    parameter int unsigned NUM_CORES         = 2,
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned THREAD_COUNT_BITS = 8,
    parameter int unsigned BLOCK_ID_BITS     = 8,
    localparam int unsigned TCW = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [THREAD_COUNT_BITS-1:0]            thread_count,
    input  logic [NUM_CORES-1:0]                    core_done,
    output logic [NUM_CORES-1:0]                    core_start,
    output logic [NUM_CORES-1:0]                    core_reset,
    output logic [NUM_CORES-1:0][BLOCK_ID_BITS-1:0] core_block_id,
    output logic [NUM_CORES-1:0][TCW-1:0]           core_thread_count,
    output logic                                    done,
    output logic                                    busy
`ifdef SCHED_CYCLE_COUNTER_EN
    ,
    output logic [31:0]                             kernel_cycles
`endif
);

    localparam int unsigned PW   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned CNTW = THREAD_COUNT_BITS + 1;

    sched_state_t    state, state_d;
    logic [CNTW-1:0] total_blocks, next_block, blocks_done, done_cnt;
    logic [TCW-1:0]  last_threads;
    logic [PW-1:0]   rr_ptr, grant_idx;
    logic [NUM_CORES-1:0] idle, grant, accepted;
    logic            grant_valid, do_grant, all_done, launch;

    // A core is idle only once both its run level and its reset pulse are gone.
    always_comb begin
        accepted = core_done & core_start;
        idle     = ~core_start & ~core_reset;
        done_cnt = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            done_cnt = done_cnt + CNTW'(accepted[i]);
        end
        launch   = (state == IDLE) && start && (thread_count != '0);
        do_grant = (state == DISPATCH) && (next_block < total_blocks) && grant_valid;
        all_done = (blocks_done + done_cnt) == total_blocks;
    end

    rr_arbiter #(
        .N  (NUM_CORES),
        .PW (PW)
    ) u_arbiter (
        .req       (idle),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .valid     (grant_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:        if (start) state_d = (thread_count != '0) ? RESET_CORES : DONE;
            RESET_CORES: state_d = DISPATCH;
            DISPATCH:    if (all_done) state_d = DONE;
            DONE:        if (!start) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_start        <= '0;
            core_reset        <= '0;
            core_block_id     <= '0;
            core_thread_count <= '0;
            done              <= 1'b0;
            busy              <= 1'b0;
            total_blocks      <= '0;
            last_threads      <= '0;
            next_block        <= '0;
            blocks_done       <= '0;
            rr_ptr            <= '0;
        end else begin
            core_reset <= '0;
            busy       <= (state_d == RESET_CORES) || (state_d == DISPATCH);
            done       <= (state_d == DONE);
            if (launch) begin
                total_blocks <= CNTW'(ceil_div(32'(thread_count), THREADS_PER_BLOCK));
                last_threads <= TCW'(32'(thread_count) % THREADS_PER_BLOCK);
                next_block   <= '0;
                blocks_done  <= '0;
                rr_ptr       <= '0;
                core_start   <= '0;
                core_reset   <= '1;
            end else begin
                for (int unsigned i = 0; i < NUM_CORES; i++) begin
                    if (accepted[i]) begin
                        core_start[i] <= 1'b0;
                        core_reset[i] <= 1'b1;
                    end
                end
                blocks_done <= blocks_done + done_cnt;
                // Grants only target idle cores, so they never collide with a completion.
                if (do_grant) begin
                    core_start[grant_idx]    <= 1'b1;
                    core_block_id[grant_idx] <= BLOCK_ID_BITS'(next_block);
                    core_thread_count[grant_idx] <=
                        ((next_block == total_blocks - CNTW'(1)) && (last_threads != '0))
                        ? last_threads : TCW'(THREADS_PER_BLOCK);
                    next_block <= next_block + CNTW'(1);
                    rr_ptr     <= (grant_idx == PW'(NUM_CORES - 1)) ? '0 : grant_idx + PW'(1);
                end
            end
        end
    end

`ifdef SCHED_CYCLE_COUNTER_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kernel_cycles <= '0;
        end else if ((state == IDLE) && start) begin
            kernel_cycles <= '0;
        end else if (busy && (kernel_cycles != '1)) begin
            kernel_cycles <= kernel_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_block_scheduler.sv
// Self-checking bench for block_scheduler: directed scenarios plus randomized
// kernels, all compared every cycle against a behavioural dispatch model.
module tb_block_scheduler;

    localparam int NC  = 2;
    localparam int TPB = 4;
    localparam int TCB = 8;
    localparam int BIB = 8;
    localparam int TCW = $clog2(TPB) + 1;

    localparam int PH_IDLE = 0, PH_RESET = 1, PH_DISPATCH = 2, PH_DONE = 3;

    logic                     clk;
    logic                     reset;
    logic                     start;
    logic [TCB-1:0]           thread_count;
    logic [NC-1:0]            core_done;
    logic [NC-1:0]            core_start;
    logic [NC-1:0]            core_reset;
    logic [NC-1:0][BIB-1:0]   core_block_id;
    logic [NC-1:0][TCW-1:0]   core_thread_count;
    logic                     done;
    logic                     busy;
`ifdef SCHED_CYCLE_COUNTER_EN
    logic [31:0]              kernel_cycles;
`endif

    block_scheduler #(
        .NUM_CORES         (NC),
        .THREADS_PER_BLOCK (TPB),
        .THREAD_COUNT_BITS (TCB),
        .BLOCK_ID_BITS     (BIB)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .thread_count      (thread_count),
        .core_done         (core_done),
        .core_start        (core_start),
        .core_reset        (core_reset),
        .core_block_id     (core_block_id),
        .core_thread_count (core_thread_count),
        .done              (done),
        .busy              (busy)
`ifdef SCHED_CYCLE_COUNTER_EN
        ,
        .kernel_cycles     (kernel_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    // Behavioural model: kernel phase, block bookkeeping and per-core view.
    int            m_phase, m_total, m_last, m_next, m_bdone, m_ptr;
    logic [NC-1:0] m_start, m_rst;
    int            m_bid [NC];
    int            m_tc  [NC];
    bit            m_done, m_busy;
    logic [31:0]   m_cycles;

    // Core emulator state.
    int lat  [NC];
    bit seen [NC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE; m_total = 0; m_last = 0; m_next = 0; m_bdone = 0; m_ptr = 0;
        m_start = '0; m_rst = '0; m_done = 0; m_busy = 0; m_cycles = '0;
        for (int i = 0; i < NC; i++) begin
            m_bid[i] = 0;
            m_tc[i]  = 0;
        end
    endtask

    task automatic model_step();
        logic [NC-1:0] acc, free;
        bit was_busy, found;
        int c;
        if (reset) begin
            model_reset();
            return;
        end
        was_busy = m_busy;
        acc      = core_done & m_start;
        free     = ~m_start & ~m_rst;
        m_rst    = '0;
        case (m_phase)
            PH_IDLE: if (start) begin
                m_cycles = '0;
                if (thread_count == 0) begin
                    m_phase = PH_DONE;
                end else begin
                    m_phase = PH_RESET;
                    m_total = (int'(thread_count) + TPB - 1) / TPB;
                    m_last  = int'(thread_count) % TPB;
                    m_next  = 0; m_bdone = 0; m_ptr = 0;
                    m_rst   = '1;
                end
            end
            PH_RESET: m_phase = PH_DISPATCH;
            PH_DISPATCH: begin
                for (int i = 0; i < NC; i++) begin
                    if (acc[i]) begin
                        m_start[i] = 1'b0;
                        m_rst[i]   = 1'b1;
                        m_bdone++;
                    end
                end
                found = 0;
                if (m_next < m_total) begin
                    for (int k = 0; k < NC; k++) begin
                        c = (m_ptr + k) % NC;
                        if (!found && free[c]) begin
                            found      = 1;
                            m_start[c] = 1'b1;
                            m_bid[c]   = m_next;
                            m_tc[c]    = (m_next == m_total - 1 && m_last != 0) ? m_last : TPB;
                            m_next++;
                            m_ptr      = (c + 1) % NC;
                        end
                    end
                end
                if (m_bdone == m_total) m_phase = PH_DONE;
            end
            default: if (!start) m_phase = PH_IDLE;
        endcase
        if (was_busy && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
        m_busy = (m_phase == PH_RESET) || (m_phase == PH_DISPATCH);
        m_done = (m_phase == PH_DONE);
    endtask

    task automatic compare_all();
        check("done", done, m_done);
        check("busy", busy, m_busy);
        check("core_start", core_start, m_start);
        check("core_reset", core_reset, m_rst);
        for (int i = 0; i < NC; i++) begin
            check("core_block_id", core_block_id[i], m_bid[i]);
            check("core_thread_count", core_thread_count[i], m_tc[i]);
        end
`ifdef SCHED_CYCLE_COUNTER_EN
        check("kernel_cycles", kernel_cycles, m_cycles);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        cyc++;
    endtask

    task automatic drive_cores();
        for (int i = 0; i < NC; i++) begin
            if (!m_start[i]) begin
                seen[i]      = 0;
                core_done[i] = ($urandom_range(0, 7) == 0);
            end else begin
                if (!seen[i]) begin
                    seen[i] = 1;
                    lat[i]  = $urandom_range(0, 6);
                end
                if (lat[i] == 0) begin
                    core_done[i] = 1'b1;
                end else begin
                    lat[i]--;
                    core_done[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic finish_kernel();
        start     = 1'b0;
        core_done = '0;
        cycle();
        check("done_cleared", done, 1'b0);
    endtask

    initial begin
        int waited, rst_at;
        bit aborted;
        reset = 1'b1; start = 1'b0; thread_count = '0; core_done = '0;
        model_reset();
        for (int i = 0; i < NC; i++) begin
            lat[i]  = 0;
            seen[i] = 0;
        end
        cycle();
        cycle();
        check("reset_core_start", core_start, 2'b00);
        check("reset_done", done, 1'b0);
        check("reset_busy", busy, 1'b0);
        reset = 1'b0;
        cycle();

        // Eight threads: two full blocks, one per core.
        start = 1'b1; thread_count = 8;
        cycle();
        check("a_e0_core_reset", core_reset, 2'b11);
        check("a_e0_busy", busy, 1'b1);
        cycle();
        check("a_e1_core_start", core_start, 2'b00);
        cycle();
        check("a_e2_core_start", core_start, 2'b01);
        check("a_e2_bid0", core_block_id[0], 0);
        check("a_e2_tc0", core_thread_count[0], 4);
        cycle();
        check("a_e3_core_start", core_start, 2'b11);
        check("a_e3_bid1", core_block_id[1], 1);
        check("a_e3_tc1", core_thread_count[1], 4);
        core_done = 2'b11;
        cycle();
        check("a_done", done, 1'b1);
        check("a_done_core_reset", core_reset, 2'b11);
        finish_kernel();

        // Ten threads: core 1 finishes first and receives the short final block.
        start = 1'b1; thread_count = 10;
        repeat (4) cycle();
        core_done = 2'b10;
        cycle();
        check("b_ed_core_reset", core_reset, 2'b10);
        check("b_ed_core_start", core_start, 2'b01);
        core_done = 2'b00;
        cycle();
        check("b_ed1_core_start", core_start, 2'b01);
        cycle();
        check("b_ed2_core_start", core_start, 2'b11);
        check("b_ed2_bid1", core_block_id[1], 2);
        check("b_ed2_tc1", core_thread_count[1], 2);
        core_done = 2'b11;
        cycle();
        check("b_done", done, 1'b1);
        finish_kernel();

        // Zero threads: straight to done with no core activity.
        start = 1'b1; thread_count = 0;
        cycle();
        check("c_done", done, 1'b1);
        check("c_busy", busy, 1'b0);
        check("c_core_reset", core_reset, 2'b00);
        check("c_core_start", core_start, 2'b00);
        finish_kernel();

        // Sixteen threads with simultaneous completion of blocks 0 and 1.
        start = 1'b1; thread_count = 16;
        repeat (4) cycle();
        core_done = 2'b11;
        cycle();
        check("d_ed_core_reset", core_reset, 2'b11);
        check("d_ed_core_start", core_start, 2'b00);
        core_done = 2'b00;
        cycle();
        cycle();
        check("d_ed2_core_start", core_start, 2'b01);
        check("d_ed2_bid0", core_block_id[0], 2);
        cycle();
        check("d_ed3_core_start", core_start, 2'b11);
        check("d_ed3_bid1", core_block_id[1], 3);
        core_done = 2'b11;
        cycle();
        check("d_done", done, 1'b1);
        finish_kernel();

        // Asynchronous reset with two blocks in flight, then a relaunch.
        start = 1'b1; thread_count = 12;
        repeat (4) cycle();
        #1 reset = 1'b1;
        model_reset();
        #1;
        check("e_async_core_start", core_start, 2'b00);
        check("e_async_busy", busy, 1'b0);
        check("e_async_bid1", core_block_id[1], 0);
        cycle();
        reset = 1'b0; thread_count = 4;
        repeat (3) cycle();
        check("e_relaunch_core_start", core_start, 2'b01);
        check("e_relaunch_bid0", core_block_id[0], 0);
        check("e_relaunch_tc0", core_thread_count[0], 4);
        core_done = 2'b01;
        cycle();
        check("e_done", done, 1'b1);
        finish_kernel();

`ifdef SCHED_CYCLE_COUNTER_EN
        // Single block finishing five cycles after its start: busy for 7 cycles.
        start = 1'b1; thread_count = 4;
        repeat (7) cycle();
        core_done = 2'b01;
        cycle();
        check("f_done", done, 1'b1);
        check("f_kernel_cycles", kernel_cycles, 7);
        core_done = 2'b00;
        cycle();
        check("f_kernel_cycles_hold", kernel_cycles, 7);
        finish_kernel();
        check("f_kernel_cycles_idle", kernel_cycles, 7);
`endif

        // Randomized kernels with random core latencies and spurious core_done.
        for (int kk = 0; kk < 40; kk++) begin
            start        = 1'b1;
            thread_count = TCB'($urandom_range(0, 40));
            core_done    = '0;
            waited       = 0;
            aborted      = 0;
            rst_at       = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 10)) : -1;
            do begin
                cycle();
                waited++;
                thread_count = TCB'($urandom_range(0, 255));
                drive_cores();
                if (waited == rst_at) begin
                    reset = 1'b1;
                    cycle();
                    reset   = 1'b0;
                    aborted = 1;
                end
            end while (!aborted && !done && waited < 400);
            if (!aborted) check("rand_kernel_done", done, 1'b1);
            start     = 1'b0;
            core_done = '0;
            repeat ($urandom_range(1, 3)) begin
                cycle();
                drive_cores();
            end
            core_done = '0;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
